donut_lane_sched: RTL and testbench
===================================

Name: donut_lane_sched

Overview:
- Shares NLANES iterative ray-march lanes (donuthit-class units) between a single in-order stream of per-pixel ray queries.
- Dispatches queries round-robin and captures each lane's hit/luma result when it completes.
- Retires results strictly in dispatch order, so the pixel pipeline upstream of the VGA output sees one ordered result stream.
- A flush input (pulsed at frame/line restart) abandons in-flight work without corrupting later results.

Parameters:
- NLANES, 2, number of march lanes (power of two, 2..8).
- LW, 6, luma width in bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  query available from ray setup stage
- req_ready  out  1  scheduler can accept query this cycle
- flush  in  1  abandon all queued/in-flight work
- lane_start  out  NLANES  one-hot, 1-cycle start pulse to lane i (lane latches its ray inputs on this pulse)
- lane_sel  out  log2(NLANES) (min 1)  index of lane being started, for the ray-input mux
- lane_done  in  NLANES  1-cycle completion pulse from lane i
- lane_hit  in  NLANES  per-lane hit result, valid with lane_done
- lane_luma  in  NLANES*LW  per-lane luma, lane i at [i*LW +: LW], valid with lane_done
- out_valid  out  1  ordered result available
- out_ready  in  1  consumer accepts result
- out_hit  out  1  retired hit flag
- out_luma  out  LW  retired luma
- err  out  1  sticky protocol error

Behaviour:
- Per-lane state: busy, rvalid, discard, hit_q, luma_q. Global state: dispatch pointer dp, retire pointer rp (both mod NLANES), err.
- Lane life cycle:
  - IDLE (!busy): start → RUN (busy=1, rvalid=0).
  - RUN: done → HELD (rvalid=1, capture hit_q/luma_q).
  - HELD: retire → IDLE.
  - FLUSHED (discard=1): done → IDLE.
- req_ready = !busy[dp] && !discard[dp] && !flush. Combinational; does not depend on req_valid.
- Accept = req_valid && req_ready. On accept:
  - lane_start[dp] pulses in the same cycle; lane_sel = dp combinationally at all times.
  - busy[dp] <= 1; dp <= dp+1 (wraps).
  - At most one start per cycle.
- lane_done[i] with busy[i] && !rvalid[i] && !discard[i]: hit_q[i], luma_q[i] <= inputs; rvalid[i] <= 1. Multiple lanes may complete in the same cycle; all are captured.
- lane_done[i] with discard[i]: discard[i] <= 0, result dropped.
- lane_done[i] with neither RUN nor discard (idle or already HELD): ignored, err <= 1.
- Output stage:
  - out_valid = rvalid[rp]; out_hit/out_luma = hit_q[rp]/luma_q[rp], combinational from the registers.
  - On out_valid && out_ready: rvalid[rp] <= 0, busy[rp] <= 0, rp <= rp+1.
  - The lane is re-dispatchable the following cycle, not the same cycle.
- Throughput: sustains one result per cycle once lanes are full. Start-to-capture latency is the lane's own; the scheduler adds 1 cycle (done→out_valid).
- Same-cycle done on lane rp and retire of lane rp cannot occur (lane rp is HELD if retiring). Done on another lane concurrent with retire: both take effect.
- Flush, highest priority:
  - For every lane in RUN: discard <= 1.
  - All busy <= 0, rvalid <= 0; dp <= 0, rp <= 0.
  - lane_start suppressed; out_valid forced 0 that cycle.
  - Discarded lanes are not dispatchable until their done arrives.
  - dp stalls on a discarded lane: no skipping, order preserved.
  - lane_done in the flush cycle for a RUN lane: result dropped, discard not set.
- Reset: all per-lane state 0, dp=rp=0, err=0. Consequently req_ready=1, lane_start=0, lane_sel=0, out_valid=0, out_hit=0, out_luma=0. Reset mid-operation drops everything, including discard flags. Lanes must be reset from the same rst.
- err is cleared only by rst.

Test Plan:
- Reset, NLANES=2: req_valid=1 continuous, lanes done 8 cycles after start, out_ready=1 → starts on lanes 0,1,0,1...; outputs in request order; req_ready low while both lanes busy.
- Out-of-order completion: start lane0, lane1; lane1 done (hit=1, luma=0x2A) 3 cycles before lane0 (hit=0, luma=0x05) → out emits 0/0x05 then 1/0x2A, back-to-back.
- Backpressure: out_ready=0 for 20 cycles with both lanes HELD → req_ready=0, out_valid=1 stable with data unchanged; release → two results on consecutive cycles.
- Flush with lane0 RUN, lane1 HELD → out_valid=0 next cycle; req_ready=0 (dp=0 discarded) until lane0 done, which produces no output; next request goes to lane0.
- Spurious lane_done[1] while lane1 idle → err=1, no output; err holds until rst.
- Reset asserted with results HELD → next cycle out_valid=0, req_ready=1, err=0, lane_sel=0.

Source files
------------

// File: rtl/donut_lane_sched.sv
// donut_lane_sched: shares NLANES iterative ray-march lanes across one
// in-order query stream. Queries are dispatched round-robin, each lane's
// hit/luma is captured on completion, and results retire strictly in
// dispatch order. A flush abandons in-flight work; lanes still marching
// when flushed are fenced off until their stale completion arrives.
module donut_lane_sched #(
   parameter int NLANES = 2,
   parameter int LW     = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       flush,
   output logic [NLANES-1:0]          lane_start,
   output logic [(NLANES > 1 ? $clog2(NLANES) : 1)-1:0] lane_sel,
   input  logic [NLANES-1:0]          lane_done,
   input  logic [NLANES-1:0]          lane_hit,
   input  logic [NLANES*LW-1:0]       lane_luma,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_hit,
   output logic [LW-1:0]              out_luma,
   output logic                       err
);

   localparam int PW = (NLANES > 1) ? $clog2(NLANES) : 1;

   // Per-lane life cycle. The busy/rvalid/discard flag triple only ever
   // takes four legal combinations, so it is carried as one state:
   //   IDLE    = !busy, !rvalid, !discard
   //   RUN     =  busy, !rvalid, !discard
   //   HELD    =  busy,  rvalid, !discard
   //   FLUSHED = !busy, !rvalid,  discard
   typedef enum logic [1:0] {
      L_IDLE,
      L_RUN,
      L_HELD,
      L_FLUSHED
   } lane_state_t;

   lane_state_t         state     [NLANES];
   lane_state_t         state_nxt [NLANES];
   logic [NLANES-1:0]   hit_q;
   logic [LW-1:0]       luma_q    [NLANES];
   logic [PW-1:0]       dp;
   logic [PW-1:0]       rp;
   logic                err_q;

   logic                accept;
   logic                retire;
   logic [NLANES-1:0]   capture;
   logic [NLANES-1:0]   spurious;

   // Dispatch/retire handshakes and result presentation from the head lane.
   always_comb begin
      req_ready = (state[dp] == L_IDLE) && !flush;
      accept    = req_valid && req_ready;
      out_valid = (state[rp] == L_HELD) && !flush;
      retire    = out_valid && out_ready;
      out_hit   = hit_q[rp];
      out_luma  = luma_q[rp];
      lane_sel  = dp;
      err       = err_q;
   end

   // One-hot start pulse to the lane at the dispatch pointer.
   always_comb begin
      lane_start = '0;
      if (accept) begin
         lane_start[dp] = 1'b1;
      end
   end

   // Per-lane next state; flush overrides dispatch and retire.
   always_comb begin
      for (int unsigned i = 0; i < NLANES; i++) begin
         state_nxt[i] = state[i];
         capture[i]   = 1'b0;
         spurious[i]  = 1'b0;
         case (state[i])
            L_IDLE: begin
               if (lane_done[i]) begin
                  spurious[i] = 1'b1;
               end
               if (accept && (dp == PW'(i))) begin
                  state_nxt[i] = L_RUN;
               end
            end
            L_RUN: begin
               // A completion landing in the flush cycle is simply dropped;
               // the lane has nothing further to report, so no fence needed.
               if (flush) begin
                  state_nxt[i] = lane_done[i] ? L_IDLE : L_FLUSHED;
               end else if (lane_done[i]) begin
                  state_nxt[i] = L_HELD;
                  capture[i]   = 1'b1;
               end
            end
            L_HELD: begin
               if (lane_done[i]) begin
                  spurious[i] = 1'b1;
               end
               if (flush) begin
                  state_nxt[i] = L_IDLE;
               end else if (retire && (rp == PW'(i))) begin
                  state_nxt[i] = L_IDLE;
               end
            end
            L_FLUSHED: begin
               if (lane_done[i]) begin
                  state_nxt[i] = L_IDLE;
               end
            end
            default: begin
               state_nxt[i] = L_IDLE;
            end
         endcase
      end
   end

   // State, captured results, pointers and sticky error register.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NLANES; i++) begin
            state[i]  <= L_IDLE;
            luma_q[i] <= '0;
         end
         hit_q <= '0;
         dp    <= '0;
         rp    <= '0;
         err_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NLANES; i++) begin
            state[i] <= state_nxt[i];
            if (capture[i]) begin
               hit_q[i]  <= lane_hit[i];
               luma_q[i] <= lane_luma[i*LW +: LW];
            end
         end
         if (flush) begin
            dp <= '0;
            rp <= '0;
         end else begin
            if (accept) begin
               dp <= dp + PW'(1);
            end
            if (retire) begin
               rp <= rp + PW'(1);
            end
         end
         if (|spurious) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_donut_lane_sched.sv
// Directed bench for donut_lane_sched with NLANES=2, LW=6: streaming with a
// fixed-latency lane model, out-of-order completion, backpressure, flush,
// spurious completion and mid-operation reset.
module tb_donut_lane_sched;

   localparam int NL = 2;
   localparam int LW = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              flush;
   logic [NL-1:0]     lane_start;
   logic [0:0]        lane_sel;
   logic [NL-1:0]     lane_done;
   logic [NL-1:0]     lane_hit;
   logic [NL*LW-1:0]  lane_luma;
   logic              out_valid;
   logic              out_ready;
   logic              out_hit;
   logic [LW-1:0]     out_luma;
   logic              err;

   // lane drive sources: fixed-latency model or hand-driven pulses
   logic              auto_en = 1'b0;
   logic              mon_en  = 1'b0;
   logic [NL-1:0]     mdl_done = '0;
   logic [NL-1:0]     mdl_hit  = '0;
   logic [NL*LW-1:0]  mdl_luma = '0;
   logic [NL-1:0]     man_done = '0;
   logic [NL-1:0]     man_hit  = '0;
   logic [NL*LW-1:0]  man_luma = '0;
   int                cnt [NL];
   int                acc_cnt = 0;
   int                ret_cnt = 0;
   int                mdl_lane;

   int n_cmp = 0;
   int n_bad = 0;

   assign lane_done = auto_en ? mdl_done : man_done;
   assign lane_hit  = auto_en ? mdl_hit  : man_hit;
   assign lane_luma = auto_en ? mdl_luma : man_luma;

   always #5 clk = ~clk;

   donut_lane_sched #(.NLANES(NL), .LW(LW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .flush      (flush),
      .lane_start (lane_start),
      .lane_sel   (lane_sel),
      .lane_done  (lane_done),
      .lane_hit   (lane_hit),
      .lane_luma  (lane_luma),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_hit    (out_hit),
      .out_luma   (out_luma),
      .err        (err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic exp_hit(input int k);
      return k[0] ^ k[1];
   endfunction

   function automatic logic [LW-1:0] exp_luma(input int k);
      return LW'((k * 11 + 3) & 63);
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Negedge: ordered-result scoreboard and 8-cycle lane model.
   always @(negedge clk) begin
      if (mon_en && out_valid && out_ready) begin
         chk("ord_hit", 32'(out_hit), 32'(exp_hit(ret_cnt)));
         chk("ord_luma", 32'(out_luma), 32'(exp_luma(ret_cnt)));
         ret_cnt++;
      end
      if (auto_en) begin
         mdl_done = '0;
         for (int i = 0; i < NL; i++) begin
            if (cnt[i] != 0) begin
               cnt[i]--;
               if (cnt[i] == 0) mdl_done[i] = 1'b1;
            end
         end
         if (req_valid && req_ready) begin
            mdl_lane = acc_cnt % NL;
            chk("rr_start", 32'(lane_start), 32'(1 << mdl_lane));
            chk("rr_sel", 32'(lane_sel), 32'(mdl_lane));
            mdl_hit[mdl_lane] = exp_hit(acc_cnt);
            mdl_luma[mdl_lane*LW +: LW] = exp_luma(acc_cnt);
            cnt[mdl_lane] = 8;
            acc_cnt++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < NL; i++) cnt[i] = 0;
      rst = 1'b1; req_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      step; step;
      // reset state
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_lane_start", 32'(lane_start), 32'd0);
      chk("rst_lane_sel", 32'(lane_sel), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_hit", 32'(out_hit), 32'd0);
      chk("rst_out_luma", 32'(out_luma), 32'd0);
      chk("rst_err", 32'(err), 32'd0);

      // streaming with 8-cycle lanes
      rst = 1'b0; auto_en = 1'b1; mon_en = 1'b1; out_ready = 1'b1; req_valid = 1'b1;
      step; step;
      chk("stream_full_ready", 32'(req_ready), 32'd0);
      chk("stream_full_start", 32'(lane_start), 32'd0);
      for (int c = 0; c < 300 && ret_cnt < 8; c++) begin
         step;
         if (acc_cnt >= 8) req_valid = 1'b0;
      end
      chk("stream_retired", 32'(ret_cnt), 32'd8);
      chk("stream_accepted", 32'(acc_cnt), 32'd8);
      auto_en = 1'b0; mon_en = 1'b0;
      step; #1;
      chk("stream_idle_ready", 32'(req_ready), 32'd1);
      chk("stream_idle_valid", 32'(out_valid), 32'd0);

      // out-of-order completion
      req_valid = 1'b1; #1;
      chk("ooo_start0", 32'(lane_start), 32'b01);
      chk("ooo_sel0", 32'(lane_sel), 32'd0);
      step;
      chk("ooo_start1", 32'(lane_start), 32'b10);
      chk("ooo_sel1", 32'(lane_sel), 32'd1);
      step;
      req_valid = 1'b0;
      step; step;
      man_done = 2'b10; man_hit = 2'b10; man_luma = {6'h2A, 6'h00};
      step;
      man_done = 2'b00; #1;
      chk("ooo_wait_head", 32'(out_valid), 32'd0);
      step; step;
      man_done = 2'b01; man_hit = 2'b10; man_luma = {6'h2A, 6'h05};
      step;
      man_done = 2'b00; #1;
      chk("ooo_r0_valid", 32'(out_valid), 32'd1);
      chk("ooo_r0_hit", 32'(out_hit), 32'd0);
      chk("ooo_r0_luma", 32'(out_luma), 32'h05);
      step;
      chk("ooo_r1_valid", 32'(out_valid), 32'd1);
      chk("ooo_r1_hit", 32'(out_hit), 32'd1);
      chk("ooo_r1_luma", 32'(out_luma), 32'h2A);
      step;
      chk("ooo_drained", 32'(out_valid), 32'd0);
      chk("ooo_ready", 32'(req_ready), 32'd1);

      // backpressure with both lanes held
      out_ready = 1'b0; req_valid = 1'b1;
      step; step;
      req_valid = 1'b0;
      man_done = 2'b11; man_hit = 2'b01; man_luma = {6'h22, 6'h11};
      step;
      man_done = 2'b00; req_valid = 1'b1; #1;
      chk("bp_ready0", 32'(req_ready), 32'd0);
      chk("bp_nostart", 32'(lane_start), 32'd0);
      chk("bp_valid0", 32'(out_valid), 32'd1);
      chk("bp_luma0", 32'(out_luma), 32'h11);
      repeat (19) step;
      chk("bp_ready19", 32'(req_ready), 32'd0);
      chk("bp_valid19", 32'(out_valid), 32'd1);
      chk("bp_hit19", 32'(out_hit), 32'd1);
      chk("bp_luma19", 32'(out_luma), 32'h11);
      req_valid = 1'b0; out_ready = 1'b1;
      step;
      chk("bp_r1_valid", 32'(out_valid), 32'd1);
      chk("bp_r1_hit", 32'(out_hit), 32'd0);
      chk("bp_r1_luma", 32'(out_luma), 32'h22);
      step;
      chk("bp_drained", 32'(out_valid), 32'd0);

      // flush with lane0 running and lane1 held
      req_valid = 1'b1;
      step; step;
      req_valid = 1'b0;
      man_done = 2'b10; man_hit = 2'b10; man_luma = {6'h33, 6'h00};
      step;
      man_done = 2'b00; flush = 1'b1; #1;
      chk("fl_ready_in_flush", 32'(req_ready), 32'd0);
      step;
      flush = 1'b0; req_valid = 1'b1; #1;
      chk("fl_valid_after", 32'(out_valid), 32'd0);
      chk("fl_ready_fenced", 32'(req_ready), 32'd0);
      chk("fl_nostart", 32'(lane_start), 32'd0);
      repeat (3) step;
      chk("fl_still_fenced", 32'(req_ready), 32'd0);
      man_done = 2'b01; man_hit = 2'b01; man_luma = {6'h00, 6'h3F};
      step;
      man_done = 2'b00; #1;
      chk("fl_stale_dropped", 32'(out_valid), 32'd0);
      chk("fl_ready_again", 32'(req_ready), 32'd1);
      chk("fl_restart_lane0", 32'(lane_start), 32'b01);
      chk("fl_no_err", 32'(err), 32'd0);
      step;
      req_valid = 1'b0;
      man_done = 2'b01; man_hit = 2'b00; man_luma = {6'h00, 6'h07};
      step;
      man_done = 2'b00; #1;
      chk("fl_new_valid", 32'(out_valid), 32'd1);
      chk("fl_new_hit", 32'(out_hit), 32'd0);
      chk("fl_new_luma", 32'(out_luma), 32'h07);
      step;

      // spurious completion on idle lane1
      man_done = 2'b10;
      step;
      man_done = 2'b00; #1;
      chk("sp_err", 32'(err), 32'd1);
      chk("sp_no_output", 32'(out_valid), 32'd0);
      repeat (5) step;
      chk("sp_err_sticky", 32'(err), 32'd1);
      chk("sp_ready", 32'(req_ready), 32'd1);

      // reset while results are held
      out_ready = 1'b0; req_valid = 1'b1;
      step; step;
      req_valid = 1'b0;
      man_done = 2'b11; man_hit = 2'b11; man_luma = {6'h15, 6'h2B};
      step;
      man_done = 2'b00; #1;
      chk("rs_held_valid", 32'(out_valid), 32'd1);
      chk("rs_held_luma", 32'(out_luma), 32'h15);
      rst = 1'b1;
      step;
      chk("rs_valid", 32'(out_valid), 32'd0);
      chk("rs_ready", 32'(req_ready), 32'd1);
      chk("rs_err", 32'(err), 32'd0);
      chk("rs_sel", 32'(lane_sel), 32'd0);
      chk("rs_luma", 32'(out_luma), 32'd0);
      rst = 1'b0;
      step;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
